// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, multiplier FSM encoding and the
// result-mux select codes that steer the multiplier product halves.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

    // Result mux selects; MUL takes prod_lo, MULH takes prod_hi.
    typedef enum logic [1:0] {
        ALU_OP_ADD  = 2'b00,
        ALU_OP_SUB  = 2'b01,
        ALU_OP_MUL  = 2'b10,
        ALU_OP_MULH = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_add_w.sv
// WIDTH-bit ripple adder with carry in/out, shared between the multiplier
// iteration and the ALU add/sub path.
module alu_add_w #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu_shift_mul.sv
// Radix-2 shift-add unsigned multiplier feeding the ALU result mux; fixed
// WIDTH-cycle latency, product registered and held until the next result.
module alu_shift_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    mul_state_e       state_r, state_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0] mq_r, mq_s;
    logic [WIDTH-1:0] mcand_r, mcand_s;
    logic [WIDTH-1:0] prod_lo_r, prod_lo_s;
    logic [WIDTH-1:0] prod_hi_r, prod_hi_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;
    logic [WIDTH-1:0] addend_s;
    logic [WIDTH-1:0] sum_lo_s;
    logic             sum_co_s;
    logic             last_iter_s;

    assign addend_s    = mq_r[0] ? mcand_r : {WIDTH{1'b0}};
    assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));

    alu_add_w #(.WIDTH(WIDTH)) u_add (
        .a    (acc_r),
        .b    (addend_s),
        .cin  (1'b0),
        .sum  (sum_lo_s),
        .cout (sum_co_s)
    );

    // Next-state and datapath update; the carry shifts into the acc MSB.
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        mq_s      = mq_r;
        mcand_s   = mcand_r;
        cnt_s     = cnt_r;
        prod_lo_s = prod_lo_r;
        prod_hi_s = prod_hi_r;
        done_s    = 1'b0;
        case (state_r)
            MUL_IDLE: begin
                if (start) begin
                    mcand_s = op_a;
                    mq_s    = op_b;
                    acc_s   = {WIDTH{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = MUL_RUN;
                end else begin
                    state_s = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                acc_s = {sum_co_s, sum_lo_s[WIDTH-1:1]};
                mq_s  = {sum_lo_s[0], mq_r[WIDTH-1:1]};
                cnt_s = cnt_r + CNT_W'(1);
                if (last_iter_s) begin
                    prod_hi_s = {sum_co_s, sum_lo_s[WIDTH-1:1]};
                    prod_lo_s = {sum_lo_s[0], mq_r[WIDTH-1:1]};
                    done_s    = 1'b1;
                    state_s   = MUL_IDLE;
                end else begin
                    state_s = MUL_RUN;
                end
            end
            default: begin
                state_s = MUL_IDLE;
            end
        endcase
        busy_s = (state_s == MUL_RUN);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= MUL_IDLE;
            acc_r     <= {WIDTH{1'b0}};
            mq_r      <= {WIDTH{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            prod_lo_r <= {WIDTH{1'b0}};
            prod_hi_r <= {WIDTH{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            acc_r     <= acc_s;
            mq_r      <= mq_s;
            mcand_r   <= mcand_s;
            cnt_r     <= cnt_s;
            prod_lo_r <= prod_lo_s;
            prod_hi_r <= prod_hi_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign prod_lo = prod_lo_r;
    assign prod_hi = prod_hi_r;

endmodule

// File: doc/alu_shift_mul.md
Name: alu_shift_mul

Overview:
- Iterative shift-add unsigned multiplier placed directly upstream of the ALU's 32-bit 4:1 result multiplexer.
- prod_lo and prod_hi drive two of the mux data inputs (MUL and MULH ops).
- Uses one adder and a radix-2 FSM, so area stays small at the cost of a fixed WIDTH-cycle latency.
- Results are registered and held, so the downstream mux sees stable operands until the next accepted operation.

Parameters:
- WIDTH, 32, operand width and width of each product half. Legal values are 2 or greater.
- CNT_W, $clog2(WIDTH), iteration counter width. Derived; never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0 and in IDLE
- op_a  in  WIDTH  multiplicand; captured on the accept edge
- op_b  in  WIDTH  multiplier; captured on the accept edge
- busy  out  1  high while an operation is in flight
- done  out  1  single-cycle pulse; product valid from this cycle on
- prod_lo  out  WIDTH  low half of op_a*op_b
- prod_hi  out  WIDTH  high half of op_a*op_b

Behaviour:
- Reset (rst_n=0, asynchronous) forces the following; all take effect without a clock edge:
  - state=IDLE
  - busy=0, done=0
  - prod_lo=0, prod_hi=0
  - acc, mq, mcand and cnt all 0
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Accept edge E0: IDLE with start=1.
  - mcand<=op_a, mq<=op_b, acc<=0, cnt<=0, state<=RUN.
  - done<=0.
  - Operand changes after E0 have no effect.
- RUN edges E1..E_WIDTH (one iteration each):
  - sum = acc + (mq[0] ? mcand : 0), formed as a WIDTH+1-bit value including carry.
  - {acc,mq} <= {sum,mq} >> 1, i.e. carry shifts into acc MSB and sum[0] into mq MSB.
  - cnt <= cnt+1.
- Final edge E_WIDTH (cnt==WIDTH-1):
  - Perform the normal iteration.
  - Load prod_hi/prod_lo from the post-iteration {acc,mq} value, not the pre-iteration registers.
  - done<=1, state<=IDLE.
- Latency:
  - done is high in the cycle following edge E_WIDTH, i.e. exactly WIDTH edges after the accept edge.
  - Latency is fixed and independent of operand values. There is no early-out on zero.
- done:
  - High for exactly one cycle, then returns to 0.
  - Stays 0 if a new start is accepted in the done cycle; the accept edge drives it to 0.
- busy:
  - Rises the cycle after E0 and falls the cycle done rises.
  - Equals (state==RUN).
- Start handling:
  - start while busy=1 is ignored: no queueing, and no effect on the running operation.
  - start in the done cycle is accepted.
  - Maximum throughput is one operation per WIDTH+1 cycles.
- prod_lo/prod_hi:
  - Change only at the final edge or on reset.
  - Hold the last product indefinitely while IDLE, including across ignored starts.
- Arithmetic:
  - Unsigned only.
  - prod_hi:prod_lo = op_a*op_b exactly (2*WIDTH bits, never truncated).
  - The adder carry out must be kept; dropping it corrupts prod_hi.
- Reset mid-operation aborts immediately with the values above. The first start after rst_n deasserts begins a clean operation.
- No X propagation: every register is reset, and all next-state logic is fully specified, including illegal state encodings, which go to IDLE.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU_WIDTH=32 constant;
  - the mul state encoding (IDLE=1'b0, RUN=1'b1);
  - the ALU op select codes used to steer prod_lo/prod_hi into the result mux.
- One sub-module: alu_add_w, a WIDTH-bit adder with carry out. It is instantiated once for the iteration sum and is reusable by the ALU add/sub path.
- The FSM, counter and shift datapath stay in alu_shift_mul.

Test Plan:
- Basic multiply and latency: reset, then start with op_a=3, op_b=5 at edge E0.
  - busy=1 from E0+1.
  - done=1 exactly after E32 for one cycle.
  - prod_lo=0x0000000F, prod_hi=0x00000000; busy=0 in the done cycle.
- Carry retention: op_a=op_b=0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001.
- High-half shift: op_a=0x80000000, op_b=2 -> prod_hi=0x00000001, prod_lo=0x00000000.
- Ignored start: start 7*9, then pulse start with op_a=100, op_b=100 at cycle 10.
  - Result is prod_lo=63.
  - Exactly one done pulse at E32.
  - prod_lo is held at 63 for 20 further idle cycles.
- Back-to-back: assert start with op_a=6, op_b=7 in the done cycle of 3*5.
  - Second done occurs 33 cycles after the first, with prod_lo=42.
  - prod_lo holds 15 until then.
- Mid-operation reset: drop rst_n at iteration 12 of 0x12345678*0x9ABCDEF0.
  - Immediately busy=0, done=0, prod_lo=prod_hi=0.
  - After release, 2*2 gives prod_lo=4 with done at exactly 32 edges.
